// File: rtl/leaf_out_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : leaf_out_arbiter
// Purpose  : Round-robin share of the leaf's BFT send path between HLS output
//            streams, wrapping each word into a 49-bit packet with per-port
//            destination, sequence address and credit flow control.
//            Optional macro ARB_BURST_EN: up to BURST_LEN words per grant.
// Revision : 1.0 - initial release
// ============================================================================
module leaf_out_arbiter #(
  parameter int NUM_PORTS     = 2,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int CREDIT_MAX    = 64,
  parameter int BURST_LEN     = 4
) (
  input  logic                                clk_user,
  input  logic                                reset,
  input  logic [NUM_PORTS*PAYLOAD_BITS-1:0]   din_user,
  input  logic [NUM_PORTS-1:0]                vld_user2arb,
  output logic [NUM_PORTS-1:0]                ack_arb2user,
  output logic [NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS:0] pkt_out,
  output logic                                pkt_vld,
  input  logic                                pkt_rdy,
  input  logic                                cfg_we,
  input  logic [3:0]                          cfg_port,
  input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0] cfg_dst,
  input  logic                                cr_vld,
  input  logic [3:0]                          cr_port,
  input  logic [6:0]                          cr_cnt
);

  localparam int c_PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int c_DW    = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int c_PKT_W = 1 + c_DW + NUM_ADDR_BITS + PAYLOAD_BITS;
  localparam int c_CW    = $clog2(CREDIT_MAX + 1);
  localparam int c_SW    = ((c_CW > 7) ? c_CW : 7) + 1;
  localparam logic [c_SW-1:0] c_CMAX = c_SW'(CREDIT_MAX);

  if (NUM_PORTS < 1 || NUM_PORTS > 16 || BURST_LEN < 1) begin : g_param_check
    $error("leaf_out_arbiter: unsupported NUM_PORTS or BURST_LEN");
  end

  // GRANT means the last cycle with a free output accepted a word, i.e. pkt_vld.
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t                   r_state;
  logic [c_PW-1:0]          r_ptr;
  logic [c_PKT_W-1:0]       r_pkt;
  logic [c_DW-1:0]          r_tbl   [NUM_PORTS];
  logic [NUM_PORTS-1:0]     r_tbl_v;
  logic [c_CW-1:0]          r_cred  [NUM_PORTS];
  logic [NUM_ADDR_BITS-1:0] r_seq   [NUM_PORTS];

  logic [NUM_PORTS-1:0]     w_elig;
  logic                     w_free;
  logic                     w_any;
  logic                     w_accept;
  logic [c_PW-1:0]          w_win;
  logic [c_PW-1:0]          w_idx;
  logic [PAYLOAD_BITS-1:0]  w_data;
  logic [c_SW-1:0]          w_sum;
  logic [c_CW-1:0]          w_cred_nxt [NUM_PORTS];

`ifdef ARB_BURST_EN
  localparam int c_BW = $clog2(BURST_LEN + 1);
  logic [c_BW-1:0] r_bcnt;
  logic            w_keep;

  assign w_keep = (r_state == ST_GRANT) && (r_bcnt < c_BW'(BURST_LEN)) && w_elig[r_ptr];
`endif

  assign pkt_vld  = (r_state == ST_GRANT);
  assign pkt_out  = r_pkt;
  assign w_free   = !pkt_vld || pkt_rdy;
  assign w_accept = w_free && w_any;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      w_elig[i] = vld_user2arb[i] && r_tbl_v[i] && (r_cred[i] != '0);
  end

  // Search starts one past the last winner; wrapping back to it last.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_idx = c_PW'((int'(r_ptr) + k) % NUM_PORTS);
      if (!w_any && w_elig[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
`ifdef ARB_BURST_EN
    if (w_keep) begin
      w_any = 1'b1;
      w_win = r_ptr;
    end
`endif
  end

  always_comb begin
    ack_arb2user = '0;
    w_data       = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      ack_arb2user[i] = w_accept && (w_win == c_PW'(i));
      if (w_win == c_PW'(i))
        w_data = din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
    end
  end

  // Returned credits and the consumed credit combine before saturation.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_sum = c_SW'(r_cred[i]);
      if (cr_vld && (cr_port == 4'(i)))
        w_sum = w_sum + c_SW'(cr_cnt);
      if (ack_arb2user[i])
        w_sum = w_sum - c_SW'(1);
      w_cred_nxt[i] = (w_sum > c_CMAX) ? c_CW'(c_CMAX) : c_CW'(w_sum);
    end
  end

  always_ff @(posedge clk_user or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_pkt   <= '0;
      r_tbl_v <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_tbl[i]  <= '0;
        r_cred[i] <= c_CW'(CREDIT_MAX);
        r_seq[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (cfg_we && (cfg_port == 4'(i))) begin
          r_tbl[i]   <= cfg_dst;
          r_tbl_v[i] <= 1'b1;
        end
        r_cred[i] <= w_cred_nxt[i];
        if (ack_arb2user[i])
          r_seq[i] <= r_seq[i] + NUM_ADDR_BITS'(1);
      end
      if (w_free)
        r_state <= w_accept ? ST_GRANT : ST_IDLE;
      if (w_accept) begin
        r_ptr <= w_win;
        r_pkt <= {1'b1, r_tbl[w_win], r_seq[w_win], w_data};
      end
    end
  end

`ifdef ARB_BURST_EN
  always_ff @(posedge clk_user or negedge reset) begin
    if (!reset)
      r_bcnt <= '0;
    else if (w_accept)
      r_bcnt <= w_keep ? (r_bcnt + c_BW'(1)) : c_BW'(1);
  end
`endif

endmodule
`default_nettype wire
